// File: rtl/rom_arbiter.sv
// rom_arbiter: three requesters share one synchronous ROM through a
// round-robin arbiter. Each ROM access runs IDLE -> ISSUE -> WAIT -> DONE;
// the ack pulse for requester i appears three cycles after its request
// is granted in IDLE.
//
// Optional feature: define ROM_ARBITER_LASTHIT_EN to keep, per requester,
// the last ROM-served address/data. A repeat read of that address is then
// answered from the stored word in IDLE, skipping the ROM (ack one cycle
// after the grant).
//
// Handshake: req[i] is a level request; addr_i is held stable while req[i]
// is high. ack[i] is a one-cycle pulse marking data_o valid for requester i.
// A requester that wants no further access drops req[i] on the edge where
// its ack is high; req[i] still high in the following IDLE is a new request.
module rom_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic [2:0]            ack,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rom_cen,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            ptr;        // requester with highest priority
  logic [1:0]            granted;    // requester owning the access in flight
  logic                  found;
  logic [1:0]            gidx;
  logic [1:0]            cand;
  logic [ADDR_WIDTH-1:0] grant_addr;

  // Successor in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // Round-robin search: ptr, ptr+1, ptr+2 (mod 3); first asserted req wins.
  always_comb begin
    found = 1'b0;
    gidx  = 2'd0;
    cand  = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Address of the winning requester; only consumed in IDLE.
  always_comb begin
    case (gidx)
      2'd1:    grant_addr = addr1;
      2'd2:    grant_addr = addr2;
      default: grant_addr = addr0;
    endcase
  end

`ifdef ROM_ARBITER_LASTHIT_EN
  logic [ADDR_WIDTH-1:0] last_addr [3];
  logic [DATA_WIDTH-1:0] last_data [3];
  logic [2:0]            last_valid;
  logic                  hit;

  assign hit = found && last_valid[gidx] && (last_addr[gidx] == grant_addr);
`endif

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Arbiter FSM; every output is registered. Reset aborts any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= 2'd0;
      granted  <= 2'd0;
      ack      <= 3'b000;
      rom_cen  <= 1'b0;
      rom_addr <= '0;
      data_o   <= '0;
`ifdef ROM_ARBITER_LASTHIT_EN
      last_valid <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        last_addr[i] <= '0;
        last_data[i] <= '0;
      end
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ack     <= 3'b000;
          rom_cen <= 1'b0;
          if (found) begin
            granted <= gidx;
            ptr     <= next_idx(gidx);
`ifdef ROM_ARBITER_LASTHIT_EN
            if (hit) begin
              data_o <= last_data[gidx];
              ack    <= onehot(gidx);
              state  <= S_DONE;
            end else
`endif
            begin
              rom_addr <= grant_addr;
              rom_cen  <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // The ROM samples rom_addr on this edge.
          rom_cen <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          data_o <= rom_data;
          ack    <= onehot(granted);
          state  <= S_DONE;
`ifdef ROM_ARBITER_LASTHIT_EN
          last_addr[granted]  <= rom_addr;
          last_data[granted]  <= rom_data;
          last_valid[granted] <= 1'b1;
`endif
        end
        default: begin
          ack   <= 3'b000;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a table of single-access vectors plus hand-written
// sequences for round-robin rotation, reset abort, a mid-access request and
// repeated reads of one address. The ROM model holds addr[7:0] ^ 8'hA5 at
// every location except 0x0123, which holds 0x5A.
module tb_rom_arbiter;
  localparam int DW = 8;
  localparam int AW = 15;

`ifdef ROM_ARBITER_LASTHIT_EN
  localparam bit LASTHIT = 1'b1;
`else
  localparam bit LASTHIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [2:0]    ack;
  logic [DW-1:0] data_o;
  logic          rom_cen;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          busy;
  logic [1:0]    fsm_state;

  rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .ack(ack), .data_o(data_o), .rom_cen(rom_cen), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Synchronous ROM: data valid the cycle after the edge with rom_cen=1.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0] ^ 8'hA5;
    mem[15'h0123] = 8'h5A;
  end
  always @(posedge clk) if (rom_cen) rom_data <= mem[rom_addr];

  // Counters.
  int checks = 0;
  int passes = 0;
  int onehot_viol = 0;

  always @(negedge clk) if ($countones(ack) > 1) onehot_viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance one cycle; sample/drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One access starting in IDLE; requester drops req once its ack shows.
  task automatic do_access(input string name, input logic [2:0] r,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [2:0] exp_ack,
                           input logic [AW-1:0] exp_addr, input logic [7:0] exp_data,
                           input int exp_lat, input int exp_cen);
    int lat;
    int cen_cnt;
    logic [AW-1:0] seen_addr;
    lat = 0; cen_cnt = 0; seen_addr = '0;
    req = r; addr0 = a0; addr1 = a1; addr2 = a2;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (rom_cen) begin
        cen_cnt++;
        seen_addr = rom_addr;
      end
      if (ack != 3'b000) begin
        lat = k;
        break;
      end
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " ack"}, {29'd0, ack}, {29'd0, exp_ack});
    check({name, " data"}, {24'd0, data_o}, {24'd0, exp_data});
    check({name, " rom_cen cycles"}, cen_cnt, exp_cen);
    if (exp_cen != 0) check({name, " rom_addr"}, {17'd0, seen_addr}, {17'd0, exp_addr});
    req = 3'b000;
    tick();
    check({name, " ack cleared"}, {29'd0, ack}, 32'd0);
    check({name, " idle"}, {31'd0, busy}, 32'd0);
    check({name, " data held"}, {24'd0, data_o}, {24'd0, exp_data});
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    check({name, " returns idle"}, ok, 1);
  endtask

  typedef struct {
    logic [2:0]    req;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    exp_ack;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    int       ack_cyc [4];
    logic [2:0] ack_v [4];
    logic [7:0] ack_d [4];
    int       exp_cyc [4];
    logic [2:0] exp_v [4];
    logic [7:0] exp_d [4];

    // Pointer walk: 0 ->1 ->0 ->2 ->1 ->1 ->2 ->0 ->1 after each grant.
    vecs[0] = '{3'b001, 15'h0123, 15'h0000, 15'h0000, 3'b001, 15'h0123, 8'h5A};
    vecs[1] = '{3'b101, 15'h0040, 15'h0000, 15'h0200, 3'b100, 15'h0200, 8'hA5};
    vecs[2] = '{3'b110, 15'h0000, 15'h1234, 15'h0201, 3'b010, 15'h1234, 8'h91};
    vecs[3] = '{3'b011, 15'h0055, 15'h1235, 15'h0000, 3'b001, 15'h0055, 8'hF0};
    vecs[4] = '{3'b001, 15'h7FFE, 15'h0000, 15'h0000, 3'b001, 15'h7FFE, 8'h5B};
    vecs[5] = '{3'b010, 15'h0000, 15'h0000, 15'h0000, 3'b010, 15'h0000, 8'hA5};
    vecs[6] = '{3'b100, 15'h0000, 15'h0000, 15'h4321, 3'b100, 15'h4321, 8'h84};
    vecs[7] = '{3'b111, 15'h00FF, 15'h0301, 15'h0302, 3'b001, 15'h00FF, 8'h5A};

    // Reset state.
    do_reset();
    check("reset ack", {29'd0, ack}, 32'd0);
    check("reset rom_cen", {31'd0, rom_cen}, 32'd0);
    check("reset rom_addr", {17'd0, rom_addr}, 32'd0);
    check("reset data_o", {24'd0, data_o}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset state", {30'd0, fsm_state}, 32'd0);

    // Table of single accesses.
    for (int i = 0; i < 8; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].req, vecs[i].a0, vecs[i].a1,
                vecs[i].a2, vecs[i].exp_ack, vecs[i].exp_addr, vecs[i].exp_data, 3, 1);
    end

    // All three requesting continuously: grants 0,1,2,0.
    do_reset();
    req = 3'b111; addr0 = 15'h0010; addr1 = 15'h0020; addr2 = 15'h0030;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ack_cyc[i] = 0; ack_v[i] = '0; ack_d[i] = '0;
    end
    exp_cyc = '{3, 7, 11, (LASTHIT ? 13 : 15)};
    exp_v   = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_d   = '{8'hB5, 8'h85, 8'h95, 8'hB5};
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (ack != 3'b000) begin
        ack_cyc[n] = c; ack_v[n] = ack; ack_d[n] = data_o;
        n++;
        if (n == 4) break;
      end
    end
    req = 3'b000;
    check("rr ack count", n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr ack%0d cycle", i), ack_cyc[i], exp_cyc[i]);
      check($sformatf("rr ack%0d grant", i), {29'd0, ack_v[i]}, {29'd0, exp_v[i]});
      check($sformatf("rr ack%0d data", i), {24'd0, ack_d[i]}, {24'd0, exp_d[i]});
    end
    tick();
    wait_idle("rr");

    // Reset in WAIT aborts the access and returns pointer to 0.
    do_reset();
    req = 3'b001; addr0 = 15'h0010;
    tick();
    check("abort issue rom_cen", {31'd0, rom_cen}, 32'd1);
    check("abort issue rom_addr", {17'd0, rom_addr}, 32'h0010);
    tick();
    check("abort in wait", {30'd0, fsm_state}, 32'd2);
    reset = 1'b1; req = 3'b000;
    tick();
    check("abort ack", {29'd0, ack}, 32'd0);
    check("abort rom_cen", {31'd0, rom_cen}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    do_access("abort ptr0", 3'b011, 15'h0010, 15'h0011, 15'h0000,
              3'b001, 15'h0010, 8'hB5, 3, 1);

    // req0 held, req1 raised during ISSUE: order 0,1,0.
    do_reset();
    req = 3'b001; addr0 = 15'h0100;
    tick();
    req = 3'b011; addr1 = 15'h0101;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ack_v[i] = '0; ack_d[i] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack != 3'b000) begin
        ack_v[n] = ack; ack_d[n] = data_o;
        n++;
        if (n == 3) break;
      end
    end
    req = 3'b000;
    check("mid ack count", n, 3);
    check("mid grant0", {29'd0, ack_v[0]}, 32'b001);
    check("mid grant1", {29'd0, ack_v[1]}, 32'b010);
    check("mid grant2", {29'd0, ack_v[2]}, 32'b001);
    check("mid data0", {24'd0, ack_d[0]}, 32'hA5);
    check("mid data1", {24'd0, ack_d[1]}, 32'hA4);
    check("mid data2", {24'd0, ack_d[2]}, 32'hA5);
    tick();
    wait_idle("mid");

    // Requester 2 reads 0x7FFF twice.
    do_reset();
    do_access("rep first", 3'b100, 15'h0000, 15'h0000, 15'h7FFF,
              3'b100, 15'h7FFF, 8'h5A, 3, 1);
    tick();
    check("rep data hold idle", {24'd0, data_o}, 32'h5A);
    do_access("rep second", 3'b100, 15'h0000, 15'h0000, 15'h7FFF,
              3'b100, 15'h7FFF, 8'h5A, (LASTHIT ? 1 : 3), (LASTHIT ? 0 : 1));

    check("ack one-hot violations", onehot_viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
